// File: rtl/sensor_timing_gen.sv
// Camera-sensor timing generator: fval/lval framing with selectable test-pattern pixel data.
// Define SENSOR_TIMING_GEN_RANDOM_EN to build in the LFSR random pattern (pattern select 2).
module sensor_timing_gen #(
    parameter int DATA_WIDTH = 10,
    parameter int HV_WD      = 16
) (
    input  logic                  clk_pix,
    input  logic                  reset_pix,
    input  logic                  i_enable,
    input  logic [HV_WD-1:0]      iv_width,
    input  logic [HV_WD-1:0]      iv_height,
    input  logic [HV_WD-1:0]      iv_hblank,
    input  logic [HV_WD-1:0]      iv_vblank,
    input  logic [1:0]            iv_pattern_sel,
    output logic                  o_fval,
    output logic                  o_lval,
    output logic [DATA_WIDTH-1:0] ov_pix_data,
    output logic                  o_frame_done,
    output logic [2:0]            ov_dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VBLANK = 3'd1,
        LEAD   = 3'd2,
        LINE   = 3'd3,
        HBLANK = 3'd4,
        TAIL   = 3'd5
    } state_t;

    localparam logic [HV_WD-1:0] ONE = HV_WD'(1);
    localparam logic [HV_WD-1:0] TWO = HV_WD'(2);

    state_t                state, next_state;
    logic [HV_WD-1:0]      cnt, line_cnt;
    logic [HV_WD-1:0]      width_q, height_q, hblank_q, vblank_q;
    logic [1:0]            sel_q;
    logic [DATA_WIDTH-1:0] frame_cnt;
    logic                  done_flag;

    logic                  live_ok, vb_last, hb_last, px_last, edge_last, more_lines, start_frame;
    logic                  fval_d, lval_d, done_d;
    logic [DATA_WIDTH-1:0] pix_d;

    assign live_ok     = i_enable && (iv_width != '0) && (iv_height != '0);
    // Zero-length blanking is stretched to one cycle so every state is visited.
    assign vb_last     = (vblank_q <= ONE) || (cnt == vblank_q - ONE);
    assign hb_last     = (hblank_q <= ONE) || (cnt == hblank_q - ONE);
    assign px_last     = (cnt == width_q - ONE);
    assign edge_last   = (cnt == TWO);
    assign more_lines  = (line_cnt != height_q - ONE);
    assign start_frame = (next_state == VBLANK) && (state != VBLANK);

`ifdef SENSOR_TIMING_GEN_RANDOM_EN
    logic [15:0] lfsr;

    // Free-running across frames; only pixel cycles advance it.
    always_ff @(posedge clk_pix or posedge reset_pix) begin
        if (reset_pix)
            lfsr <= 16'hACE1;
        else if (state == LINE)
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
`endif

    always_ff @(posedge clk_pix or posedge reset_pix) begin
        if (reset_pix) begin
            state        <= IDLE;
            cnt          <= '0;
            line_cnt     <= '0;
            width_q      <= '0;
            height_q     <= '0;
            hblank_q     <= '0;
            vblank_q     <= '0;
            sel_q        <= '0;
            frame_cnt    <= '0;
            done_flag    <= 1'b0;
            o_fval       <= 1'b0;
            o_lval       <= 1'b0;
            ov_pix_data  <= '0;
            o_frame_done <= 1'b0;
        end else begin
            state <= next_state;
            if ((next_state != state) || (state == IDLE))
                cnt <= '0;
            else
                cnt <= cnt + ONE;

            if (start_frame) begin
                width_q  <= iv_width;
                height_q <= iv_height;
                hblank_q <= iv_hblank;
                vblank_q <= iv_vblank;
                sel_q    <= iv_pattern_sel;
                line_cnt <= '0;
            end else if ((state == LINE) && px_last) begin
                line_cnt <= line_cnt + ONE;
            end

            done_flag <= (state == TAIL) && edge_last;
            if (done_flag)
                frame_cnt <= frame_cnt + 1'b1;

            // One register stage for every output keeps fval, lval and data aligned.
            o_fval       <= fval_d;
            o_lval       <= lval_d;
            ov_pix_data  <= pix_d;
            o_frame_done <= done_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (live_ok) next_state = VBLANK;
            VBLANK:  if (vb_last) next_state = LEAD;
            LEAD:    if (edge_last) next_state = LINE;
            LINE:    if (px_last) next_state = more_lines ? HBLANK : TAIL;
            HBLANK:  if (hb_last) next_state = LINE;
            TAIL:    if (edge_last) next_state = live_ok ? VBLANK : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        fval_d = (state == LEAD) || (state == LINE) || (state == HBLANK) || (state == TAIL);
        lval_d = (state == LINE);
        done_d = done_flag;
        pix_d  = '0;
        if (state == LINE) begin
            case (sel_q)
                2'd0:    pix_d = DATA_WIDTH'(line_cnt);
                2'd1:    pix_d = frame_cnt;
`ifdef SENSOR_TIMING_GEN_RANDOM_EN
                2'd2:    pix_d = lfsr[DATA_WIDTH-1:0];
`else
                2'd2:    pix_d = DATA_WIDTH'(line_cnt);
`endif
                default: pix_d = '0;
            endcase
        end
    end

    assign ov_dbg_state = state;

endmodule

// File: tb/tb_sensor_timing_gen.sv
// Scoreboard bench for sensor_timing_gen: drivers queue expected lines/frames, a negedge monitor checks them.
module tb_sensor_timing_gen;
    localparam int DW = 8;
    localparam int HV = 16;

    logic          clk_pix = 1'b0;
    logic          reset_pix = 1'b1;
    logic          i_enable = 1'b0;
    logic [HV-1:0] iv_width = '0, iv_height = '0, iv_hblank = '0, iv_vblank = '0;
    logic [1:0]    iv_pattern_sel = '0;
    logic          o_fval, o_lval, o_frame_done;
    logic [DW-1:0] ov_pix_data;
    logic [2:0]    ov_dbg_state;

    sensor_timing_gen #(.DATA_WIDTH(DW), .HV_WD(HV)) dut (
        .clk_pix(clk_pix), .reset_pix(reset_pix), .i_enable(i_enable),
        .iv_width(iv_width), .iv_height(iv_height), .iv_hblank(iv_hblank),
        .iv_vblank(iv_vblank), .iv_pattern_sel(iv_pattern_sel),
        .o_fval(o_fval), .o_lval(o_lval), .ov_pix_data(ov_pix_data),
        .o_frame_done(o_frame_done), .ov_dbg_state(ov_dbg_state)
    );

    always #5 clk_pix = ~clk_pix;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0]   exp_line_q[$];   // {line length, pixel value}
    logic [15:0]   exp_frame_q[$];  // lines per frame
    logic [DW-1:0] exp_pix_q[$];    // per-pixel values for the random pattern
    bit            rand_mode = 1'b0;
    int            done_cnt = 0, fstart_cnt = 0, cur_lines = 0;
    logic [DW-1:0] fcnt_model = '0;
    logic [15:0]   lfsr_model = 16'hACE1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: reconstructs lines and frames from the output stream.
    int            cyc = 0, t_frise = 0, t_lfall = 0, llen = 0;
    logic          pf = 1'b0, pl = 1'b0, lflat = 1'b1;
    logic [DW-1:0] ldata = '0;

    always @(negedge clk_pix) begin
        if (reset_pix) begin
            pf = 1'b0;
            pl = 1'b0;
        end else begin
            cyc++;
            if (o_fval && !pf) begin
                t_frise = cyc;
                cur_lines = 0;
                fstart_cnt++;
            end
            if (o_lval && !pl) begin
                if (cur_lines == 0) check("lead_gap", 64'(cyc - t_frise), 64'd3);
                cur_lines++;
                llen  = 0;
                lflat = 1'b1;
                ldata = ov_pix_data;
            end
            if (o_lval) begin
                llen++;
                if (ov_pix_data !== ldata) lflat = 1'b0;
                if (rand_mode) begin
                    if (exp_pix_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL pix_extra: got 0x%0h, expected no pixel", ov_pix_data);
                    end else begin
                        check("rand_pix", 64'(ov_pix_data), 64'(exp_pix_q.pop_front()));
                    end
                end
            end
            if (!o_lval && pl) begin
                t_lfall = cyc;
                check("blank_data", 64'(ov_pix_data), 64'd0);
                if (!rand_mode) begin
                    if (exp_line_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL line_extra: got len %0d data 0x%0h, expected no line", llen, ldata);
                    end else begin
                        check("line", 64'({llen[15:0], ldata, lflat}), 64'({exp_line_q.pop_front(), 1'b1}));
                    end
                end
            end
            if (!o_fval && pf) begin
                check("tail_gap", 64'(cyc - t_lfall), 64'd3);
                check("frame_done", 64'(o_frame_done), 64'd1);
                if (exp_frame_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL frame_extra: got %0d lines, expected no frame", cur_lines);
                end else begin
                    check("frame_lines", 64'(cur_lines), 64'(exp_frame_q.pop_front()));
                end
            end
            if (o_frame_done) done_cnt++;
            pf = o_fval;
            pl = o_lval;
        end
    end

    task automatic set_geo(input int w, input int h, input int hb, input int vb, input int sel);
        iv_width       = HV'(w);
        iv_height      = HV'(h);
        iv_hblank      = HV'(hb);
        iv_vblank      = HV'(vb);
        iv_pattern_sel = 2'(sel);
    endtask

    task automatic push_frame(input int w, input int h, input int sel);
        logic [DW-1:0] d;
        for (int l = 0; l < h; l++) begin
            case (sel)
                1:       d = fcnt_model;
                3:       d = '0;
                default: d = DW'(l);
            endcase
`ifdef SENSOR_TIMING_GEN_RANDOM_EN
            if (sel == 2) begin
                for (int p = 0; p < w; p++) begin
                    exp_pix_q.push_back(lfsr_model[DW-1:0]);
                    lfsr_model = {lfsr_model[0] ^ lfsr_model[2] ^ lfsr_model[3] ^ lfsr_model[5], lfsr_model[15:1]};
                end
                continue;
            end
`endif
            exp_line_q.push_back({16'(w), d});
        end
        exp_frame_q.push_back(16'(h));
        fcnt_model++;
    endtask

    function automatic int get_cnt(input int which);
        case (which)
            0:       return fstart_cnt;
            1:       return done_cnt;
            default: return cur_lines;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int target);
        int k = 0;
        while (k < 20000 && get_cnt(which) < target) begin
            @(negedge clk_pix);
            k++;
        end
        if (get_cnt(which) < target) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: count %0d, expected %0d", name, get_cnt(which), target);
        end
    endtask

    // Holds enable until the last requested frame has started, then lets it finish.
    task automatic run_frames(input string name, input int n);
        int s0 = fstart_cnt + n;
        int d0 = done_cnt + n;
        i_enable = 1'b1;
        wait_for(name, 0, s0);
        i_enable = 1'b0;
        wait_for(name, 1, d0);
        repeat (5) @(negedge clk_pix);
    endtask

    task automatic clear_model();
        exp_line_q.delete();
        exp_frame_q.delete();
        exp_pix_q.delete();
        fcnt_model = '0;
        lfsr_model = 16'hACE1;
    endtask

    task automatic do_reset();
        @(negedge clk_pix);
        reset_pix = 1'b1;
        repeat (2) @(negedge clk_pix);
        clear_model();
        reset_pix = 1'b0;
        @(negedge clk_pix);
    endtask

    task automatic check_drained(input string name);
        check({name, "_lines_left"}, 64'(exp_line_q.size()), 64'd0);
        check({name, "_frames_left"}, 64'(exp_frame_q.size()), 64'd0);
        check({name, "_pix_left"}, 64'(exp_pix_q.size()), 64'd0);
    endtask

    initial begin
        int s0, d0, k;
        logic [15:0] pat;
        logic prev;

        repeat (3) @(negedge clk_pix);
        check("reset_state", 64'({o_fval, o_lval, ov_pix_data, o_frame_done, ov_dbg_state}), 64'd0);
        reset_pix = 1'b0;
        @(negedge clk_pix);

        // Pattern 2 straight after reset: LFSR from seed, or line-inc when not built in.
        set_geo(4, 2, 2, 3, 2);
        push_frame(4, 2, 2);
`ifdef SENSOR_TIMING_GEN_RANDOM_EN
        rand_mode = 1'b1;
`endif
        run_frames("rand", 1);
        rand_mode = 1'b0;
        check_drained("rand");

        // Line-increment: 3 full-size frames, then 27 smaller ones, 30 frame_done pulses total.
        d0 = done_cnt;
        set_geo(64, 64, 8, 20, 0);
        for (int f = 0; f < 3; f++) push_frame(64, 64, 0);
        run_frames("lineinc64", 3);
        set_geo(8, 8, 8, 20, 0);
        for (int f = 0; f < 27; f++) push_frame(8, 8, 0);
        run_frames("lineinc8", 27);
        check("done_30", 64'(done_cnt - d0), 64'd30);
        check_drained("lineinc");

        // Frame-increment from reset: frames carry 0..4.
        do_reset();
        set_geo(4, 2, 1, 2, 1);
        for (int f = 0; f < 5; f++) push_frame(4, 2, 1);
        run_frames("frameinc", 5);
        check_drained("frameinc");

        // 1x1 frames with no blanking: 8-cycle cadence, frame counter wraps 255 -> 0.
        set_geo(1, 1, 0, 0, 1);
        for (int f = 0; f < 260; f++) push_frame(1, 1, 1);
        s0 = fstart_cnt + 260;
        d0 = done_cnt + 260;
        i_enable = 1'b1;
        wait_for("tiny_mid", 0, fstart_cnt + 100);
        prev = o_fval;
        k = 0;
        @(negedge clk_pix);
        while (k < 50 && !(prev && !o_fval)) begin
            prev = o_fval;
            @(negedge clk_pix);
            k++;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_pix);
            pat[i] = o_fval;
        end
        check("tiny_fval_cadence", 64'(pat), 64'h7F7F);
        wait_for("tiny", 0, s0);
        i_enable = 1'b0;
        wait_for("tiny", 1, d0);
        repeat (5) @(negedge clk_pix);
        check_drained("tiny");

        // Enable dropped at line 10: the frame completes, then the block idles.
        set_geo(8, 64, 8, 20, 0);
        push_frame(8, 64, 0);
        s0 = fstart_cnt;
        d0 = done_cnt;
        i_enable = 1'b1;
        wait_for("endrop_start", 0, s0 + 1);
        wait_for("endrop_line10", 2, 10);
        i_enable = 1'b0;
        wait_for("endrop_done", 1, d0 + 1);
        repeat (300) @(negedge clk_pix);
        check("endrop_no_restart", 64'(fstart_cnt), 64'(s0 + 1));
        check("endrop_idle", 64'({o_fval, ov_dbg_state}), 64'd0);
        check_drained("endrop");

        // Width changed mid-frame only takes effect on the next frame.
        set_geo(64, 4, 8, 20, 0);
        push_frame(64, 4, 0);
        push_frame(32, 4, 0);
        s0 = fstart_cnt;
        d0 = done_cnt;
        i_enable = 1'b1;
        wait_for("wchg_f1", 0, s0 + 1);
        iv_width = HV'(32);
        wait_for("wchg_f2", 0, s0 + 2);
        i_enable = 1'b0;
        wait_for("wchg_done", 1, d0 + 2);
        repeat (5) @(negedge clk_pix);
        check_drained("wchg");

        // Reset during a line clears the outputs asynchronously; next frame gets a full vblank.
        set_geo(16, 4, 4, 20, 0);
        s0 = fstart_cnt;
        i_enable = 1'b1;
        wait_for("rst_start", 0, s0 + 1);
        k = 0;
        while (!o_lval && k < 200) begin
            @(negedge clk_pix);
            k++;
        end
        check("rst_in_line", 64'(o_lval), 64'd1);
        #3 reset_pix = 1'b1;
        #1 check("rst_async_clear", 64'({o_fval, o_lval, ov_pix_data}), 64'd0);
        @(negedge clk_pix);
        @(negedge clk_pix);
        clear_model();
        push_frame(16, 4, 0);
        s0 = fstart_cnt;
        d0 = done_cnt;
        reset_pix = 1'b0;
        k = 0;
        do begin
            @(posedge clk_pix);
            k++;
            @(negedge clk_pix);
        end while (!o_fval && k < 100);
        check("rst_full_vblank", 64'(k), 64'd22);
        wait_for("rst_frame", 0, s0 + 1);
        i_enable = 1'b0;
        wait_for("rst_done", 1, d0 + 1);
        repeat (5) @(negedge clk_pix);
        check_drained("rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
